fetch_sequencer: RTL
====================

# fetch_sequencer

Multi-cycle fetch/execute controller for the single-issue word-addressed CPU. Owns the architectural PC register and fetches each instruction from instruction memory over a req/ack handshake. Presents the instruction to the decode/execute datapath, then commits the next-PC value computed by the next-PC logic. Sits between the instruction memory port, the next-PC logic (which consumes `pc` and `instr`) and the execute stage (which signals completion).

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word address).
- `TIMEOUT`, 15, max cycles in FETCH without `imem_ack` before fault; legal range 1..255.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request, level-held until ack.
- `imem_addr` out 32: fetch word address; equals `pc`.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; ignored unless `imem_req`=1.
- `imem_rdata` in 32: instruction word.
- `new_pc` in 32: next PC from next-PC logic, sampled at commit.
- `exec_done` in 1: execute stage has finished the current instruction.
- `stall` in 1: blocks commit while high.
- `pc` out 32: current PC.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: `instr` is valid for decode/execute.
- `retire` out 1: one-cycle pulse on commit.
- `retire_count` out 32: number of committed instructions.
- `halted` out 1: sticky halt indicator (see Configuration).
- `fetch_err` out 1: sticky fetch-timeout fault.

## Operation

- States: FETCH, EXEC, HALT, ERROR.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_valid`<=1, timeout counter cleared, go to EXEC.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT` without ack: `fetch_err`<=1, go to ERROR.
- EXEC:
  - `imem_req`=0 and `instr_valid`=1.
  - Commit condition is `exec_done`=1 and `stall`=0. On commit: `pc`<=`new_pc`, `instr_valid`<=0, `retire`=1 for that cycle, `retire_count`+=1, go to FETCH.
  - If `exec_done` arrives with `stall`=1: no commit; `exec_done` must be re-asserted (level) and is sampled each cycle.
- HALT, ERROR: terminal until `rst`. `imem_req`=0, `instr_valid`=0, `pc` and `instr` frozen.
- `retire_count` is 32-bit unsigned and wraps from 32'hFFFF_FFFF to 0.
- `new_pc` is taken as-is: no alignment, no range check, full 32-bit.
- `imem_ack` outside FETCH is ignored with no state change.

## Timing

- Reset values: `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `retire`=0, `retire_count`=0, `halted`=0, `fetch_err`=0, timeout counter=0, state=FETCH.
- First `imem_req` is asserted in the cycle after `rst` deasserts.
- Fetch latency is 1 cycle minimum: ack in the first FETCH cycle gives `instr_valid`=1 on the next cycle.
- Commit-to-next-request is 1 cycle: `pc` updates on the commit edge, and `imem_req` rises the same edge with the new `imem_addr`.
- Minimum instruction period is 2 cycles (FETCH with immediate ack, then EXEC with `exec_done` held high).
- Fault timing: with `TIMEOUT`=N and no ack, `fetch_err` rises at the end of FETCH cycle N. An ack in cycle N wins over timeout.
- `rst` asserted mid-operation (any state, including a pending request): all state returns to reset values on that edge. An in-flight ack is discarded.

## Configuration

- Macro: `FETCH_SEQ_HALT_EN`.
- Defined:
  - In EXEC, if `instr[31:26]`==6'h3F, the commit condition moves to HALT instead of FETCH.
  - `halted`<=1 and `retire` pulses.
  - `retire_count` increments.
  - `pc` is NOT updated.
- Not defined:
  - Opcode 6'h3F commits like any other instruction.
  - `halted` is tied to 0 and the HALT state is unreachable.

## Test plan

- Reset, RESET_PC=32'h10, memory acks immediately, `exec_done` held high, `new_pc`=`pc`+1 → `imem_addr` sequence 0x10, 0x11, 0x12 on every other cycle; `retire_count`=3 after six cycles of operation.
- Ack delayed 3 cycles → `imem_req` held 3 cycles with stable `imem_addr`; `instr` = returned word on the cycle after ack; no `fetch_err`.
- TIMEOUT=4, no ack → `fetch_err`=1 after exactly 4 FETCH cycles; `imem_req`=0 thereafter; ack ignored afterwards.
- EXEC with `exec_done`=1 and `stall`=1 for 2 cycles, then `stall`=0 → no commit, then exactly one `retire` pulse; `pc` = `new_pc` sampled on the unstalled cycle (e.g. 0x40).
- `FETCH_SEQ_HALT_EN` defined, fetch 32'hFC00_0000 at pc=0x5 → `halted`=1, `pc` stays 0x5, `retire_count` increments by 1, no further `imem_req`; without the macro → `pc`=`new_pc` and fetching continues.
- `rst` pulsed while `imem_req`=1 and again in EXEC with `retire_count`=7 → all outputs return to reset values the next cycle; `retire_count`=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute controller: owns the PC, fetches over req/ack, commits next PC.
// Optional halt-opcode support is enabled by defining FETCH_SEQ_HALT_EN.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic [31:0] new_pc,
   input  logic        exec_done,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        retire,
   output logic [31:0] retire_count,
   output logic        halted,
   output logic        fetch_err
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;
   localparam logic [1:0] ST_ERROR = 2'd3;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0]  state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic        instr_valid_reg, instr_valid_next;
   logic        imem_req_reg, imem_req_next;
   logic        retire_reg, retire_next;
   logic [31:0] retire_count_reg, retire_count_next;
   logic        halted_reg, halted_next;
   logic        fetch_err_reg, fetch_err_next;
   logic [7:0]  tmo_cnt_reg, tmo_cnt_next;

   logic        commit;
   logic        halt_op;

`ifdef FETCH_SEQ_HALT_EN
   assign halt_op = (instr_reg[31:26] == 6'h3F);
`else
   assign halt_op = 1'b0;
`endif

   assign commit = (state_reg == ST_EXEC) && exec_done && !stall;

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      instr_next        = instr_reg;
      instr_valid_next  = instr_valid_reg;
      retire_next       = 1'b0;
      retire_count_next = retire_count_reg;
      halted_next       = halted_reg;
      fetch_err_next    = fetch_err_reg;
      tmo_cnt_next      = tmo_cnt_reg;

      case (state_reg)
         ST_FETCH: begin
            // The first FETCH cycle after reset only raises the request; ack is honoured once it is up.
            if (imem_req_reg) begin
               if (imem_ack) begin
                  instr_next       = imem_rdata;
                  instr_valid_next = 1'b1;
                  tmo_cnt_next     = 8'd0;
                  state_next       = ST_EXEC;
               end else if (tmo_cnt_reg + 8'd1 == TIMEOUT_CNT) begin
                  tmo_cnt_next   = tmo_cnt_reg + 8'd1;
                  fetch_err_next = 1'b1;
                  state_next     = ST_ERROR;
               end else begin
                  tmo_cnt_next = tmo_cnt_reg + 8'd1;
               end
            end
         end
         ST_EXEC: begin
            if (commit) begin
               retire_next       = 1'b1;
               retire_count_next = retire_count_reg + 32'd1;
               instr_valid_next  = 1'b0;
               if (halt_op) begin
                  halted_next = 1'b1;
                  state_next  = ST_HALT;
               end else begin
                  pc_next    = new_pc;
                  state_next = ST_FETCH;
               end
            end
         end
         ST_HALT, ST_ERROR: begin
            state_next = state_reg;
         end
         default: begin
            state_next = ST_ERROR;
         end
      endcase

      // Request is registered so it rises on the same edge that enters FETCH with the new PC.
      imem_req_next = (state_next == ST_FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ST_FETCH;
         pc_reg           <= RESET_PC;
         instr_reg        <= 32'd0;
         instr_valid_reg  <= 1'b0;
         imem_req_reg     <= 1'b0;
         retire_reg       <= 1'b0;
         retire_count_reg <= 32'd0;
         halted_reg       <= 1'b0;
         fetch_err_reg    <= 1'b0;
         tmo_cnt_reg      <= 8'd0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         instr_reg        <= instr_next;
         instr_valid_reg  <= instr_valid_next;
         imem_req_reg     <= imem_req_next;
         retire_reg       <= retire_next;
         retire_count_reg <= retire_count_next;
         halted_reg       <= halted_next;
         fetch_err_reg    <= fetch_err_next;
         tmo_cnt_reg      <= tmo_cnt_next;
      end
   end

   assign imem_req     = imem_req_reg;
   assign imem_addr    = pc_reg;
   assign pc           = pc_reg;
   assign instr        = instr_reg;
   assign instr_valid  = instr_valid_reg;
   assign retire       = retire_reg;
   assign retire_count = retire_count_reg;
   assign halted       = halted_reg;
   assign fetch_err    = fetch_err_reg;

endmodule
